// File: rtl/exc_commit_ctrl.sv
// Commit-side event generator: prioritises interrupts/exceptions/ERTN/refetch/IDLE at writeback
// and pulses them to the CSR unit. Optional trace counters are enabled with `define EXC_TRACE_EN.
module exc_commit_ctrl #(
  parameter int         HOLDOFF  = 2,
  parameter logic [5:0] INT_CODE = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_exc,
  input  logic [5:0]  wb_excode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_badv,
  input  logic        wb_ertn,
  input  logic        wb_refetch,
  input  logic        wb_idle,
  input  logic [11:0] csr_is,
  input  logic [11:0] csr_lie,
  input  logic        csr_ie,
  output logic        commit_ok,
  output logic        flush,
  output logic        idle_stall,
  output logic        is_exc,
  output logic [5:0]  excode,
  output logic [8:0]  esubcode,
  output logic [31:0] badvaddr,
  output logic [31:0] csr_pc,
  output logic        is_ertn,
  output logic        is_fetch_again,
  output logic        is_idle,
`ifdef EXC_TRACE_EN
  output logic [31:0] exc_count,
  output logic [5:0]  last_excode,
`endif
  output logic [1:0]  dbg_state
);

  localparam int CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLDOFF);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_IDLE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t         r_state, w_state_n;
  logic [CW-1:0]  r_cnt, w_cnt_n;
  logic           w_int_pend;
  logic           w_go_exc, w_go_ertn, w_go_refetch, w_go_idle;
  logic           w_pay_int, w_pay_pipe, w_ld_pc;
  logic           w_commit, w_flush;

  logic           r_is_exc, r_is_ertn, r_is_fetch_again, r_is_idle;
  logic [5:0]     r_excode;
  logic [8:0]     r_esubcode;
  logic [31:0]    r_badvaddr;
  logic [31:0]    r_csr_pc;

  assign w_int_pend = csr_ie & (|(csr_is & csr_lie));

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_go_exc     = 1'b0;
    w_go_ertn    = 1'b0;
    w_go_refetch = 1'b0;
    w_go_idle    = 1'b0;
    w_pay_int    = 1'b0;
    w_pay_pipe   = 1'b0;
    w_ld_pc      = 1'b0;
    w_commit     = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (wb_valid) begin
          w_ld_pc = 1'b1;
          w_flush = 1'b1;
          if (w_int_pend) begin
            w_go_exc  = 1'b1;
            w_pay_int = 1'b1;
          end else if (wb_exc) begin
            w_go_exc   = 1'b1;
            w_pay_pipe = 1'b1;
          end else if (wb_ertn) begin
            w_go_ertn = 1'b1;
            w_commit  = 1'b1;
          end else if (wb_refetch) begin
            w_go_refetch = 1'b1;
            w_commit     = 1'b1;
          end else if (wb_idle) begin
            w_go_idle = 1'b1;
            w_commit  = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            // Ordinary retirement: no event, nothing to flush.
            w_ld_pc  = 1'b0;
            w_flush  = 1'b0;
            w_commit = 1'b1;
          end
          if (w_go_exc || w_go_ertn || w_go_refetch) begin
            w_state_n = (HOLDOFF == 0) ? S_RUN : S_HOLD;
            w_cnt_n   = HOLD_INIT;
          end
        end
      end
      S_IDLE: begin
        w_flush = 1'b1;
        // Wake-up keeps csr_pc at the IDLE instruction's PC latched on entry.
        if (w_int_pend) begin
          w_go_exc  = 1'b1;
          w_pay_int = 1'b1;
          w_state_n = (HOLDOFF == 0) ? S_RUN : S_HOLD;
          w_cnt_n   = HOLD_INIT;
        end
      end
      S_HOLD: begin
        w_flush = 1'b1;
        w_cnt_n = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) w_state_n = S_RUN;
      end
      default: w_state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_RUN;
      r_cnt            <= '0;
      r_is_exc         <= 1'b0;
      r_is_ertn        <= 1'b0;
      r_is_fetch_again <= 1'b0;
      r_is_idle        <= 1'b0;
      r_excode         <= '0;
      r_esubcode       <= '0;
      r_badvaddr       <= '0;
      r_csr_pc         <= '0;
    end else begin
      r_state          <= w_state_n;
      r_cnt            <= w_cnt_n;
      r_is_exc         <= w_go_exc;
      r_is_ertn        <= w_go_ertn;
      r_is_fetch_again <= w_go_refetch;
      r_is_idle        <= w_go_idle;
      if (w_ld_pc) r_csr_pc <= wb_pc;
      if (w_pay_int) begin
        r_excode   <= INT_CODE;
        r_esubcode <= '0;
        r_badvaddr <= '0;
      end else if (w_pay_pipe) begin
        r_excode   <= wb_excode;
        r_esubcode <= wb_esubcode;
        r_badvaddr <= wb_badv;
      end
    end
  end

`ifdef EXC_TRACE_EN
  logic [31:0] r_exc_count;
  logic [5:0]  r_last_excode;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc_count   <= '0;
      r_last_excode <= '0;
    end else if (w_go_exc) begin
      r_exc_count   <= r_exc_count + 32'd1;
      r_last_excode <= w_pay_int ? INT_CODE : wb_excode;
    end
  end

  assign exc_count   = r_exc_count;
  assign last_excode = r_last_excode;
`endif

  // Combinational controls are forced quiet while reset is held.
  assign commit_ok      = w_commit & ~reset;
  assign flush          = w_flush & ~reset;
  assign idle_stall     = (r_state == S_IDLE) & ~reset;
  assign is_exc         = r_is_exc;
  assign is_ertn        = r_is_ertn;
  assign is_fetch_again = r_is_fetch_again;
  assign is_idle        = r_is_idle;
  assign excode         = r_excode;
  assign esubcode       = r_esubcode;
  assign badvaddr       = r_badvaddr;
  assign csr_pc         = r_csr_pc;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model of the commit/event rules.
module tb_exc_commit_ctrl;
  localparam int         HOLDOFF  = 2;
  localparam logic [5:0] INT_CODE = 6'h00;

  logic        clk, reset;
  logic        wb_valid, wb_exc, wb_ertn, wb_refetch, wb_idle, csr_ie;
  logic [31:0] wb_pc, wb_badv;
  logic [5:0]  wb_excode;
  logic [8:0]  wb_esubcode;
  logic [11:0] csr_is, csr_lie;
  logic        commit_ok, flush, idle_stall, is_exc, is_ertn, is_fetch_again, is_idle;
  logic [5:0]  excode;
  logic [8:0]  esubcode;
  logic [31:0] badvaddr, csr_pc;
  logic [1:0]  dbg_state;
`ifdef EXC_TRACE_EN
  logic [31:0] exc_count;
  logic [5:0]  last_excode;
`endif

  int errors = 0;
  int checks = 0;

  exc_commit_ctrl #(.HOLDOFF(HOLDOFF), .INT_CODE(INT_CODE)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc), .wb_excode(wb_excode),
    .wb_esubcode(wb_esubcode), .wb_badv(wb_badv), .wb_ertn(wb_ertn),
    .wb_refetch(wb_refetch), .wb_idle(wb_idle),
    .csr_is(csr_is), .csr_lie(csr_lie), .csr_ie(csr_ie),
    .commit_ok(commit_ok), .flush(flush), .idle_stall(idle_stall),
    .is_exc(is_exc), .excode(excode), .esubcode(esubcode), .badvaddr(badvaddr),
    .csr_pc(csr_pc), .is_ertn(is_ertn), .is_fetch_again(is_fetch_again), .is_idle(is_idle),
`ifdef EXC_TRACE_EN
    .exc_count(exc_count), .last_excode(last_excode),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid = 0; wb_pc = '0; wb_exc = 0; wb_excode = '0; wb_esubcode = '0;
    wb_badv = '0; wb_ertn = 0; wb_refetch = 0; wb_idle = 0;
  endtask

  task automatic clear_all();
    clear_wb();
    csr_is = '0; csr_lie = '0; csr_ie = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_all();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < HOLDOFF + 1; i++) tick();
  endtask

  function automatic logic [3:0] pulses();
    return {is_exc, is_ertn, is_fetch_again, is_idle};
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (pulses() !== 4'b0000) begin errors++; $display("FAIL reset_pulses got=%b exp=0000", pulses()); end
    checks++;
    if ({commit_ok, flush, idle_stall} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl got=%b exp=000", {commit_ok, flush, idle_stall});
    end
    checks++;
    if ({excode, esubcode, badvaddr, csr_pc} !== '0) begin
      errors++; $display("FAIL reset_payload got=%h/%h/%h/%h exp=0", excode, esubcode, badvaddr, csr_pc);
    end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_exc();
    wb_valid = 1; wb_exc = 1; wb_excode = 6'h09; wb_esubcode = 9'h005;
    wb_badv = 32'h1003; wb_pc = 32'h1c000100;
    @(negedge clk);
    checks++;
    if ({flush, commit_ok} !== 2'b10) begin errors++; $display("FAIL exc_T got=%b exp=10", {flush, commit_ok}); end
    tick();
    clear_wb();
    wb_valid = 1; wb_pc = 32'h1c000104;
    checks++;
    if (pulses() !== 4'b1000) begin errors++; $display("FAIL exc_pulse got=%b exp=1000", pulses()); end
    checks++;
    if ({excode, esubcode, badvaddr, csr_pc} !== {6'h09, 9'h005, 32'h1003, 32'h1c000100}) begin
      errors++; $display("FAIL exc_payload got=%h/%h/%h/%h exp=09/005/1003/1c000100", excode, esubcode, badvaddr, csr_pc);
    end
    for (int i = 0; i < HOLDOFF; i++) begin
      @(negedge clk);
      checks++;
      if ({commit_ok, flush} !== 2'b01) begin errors++; $display("FAIL exc_hold%0d got=%b exp=01", i, {commit_ok, flush}); end
      tick();
      checks++;
      if (pulses() !== 4'b0000) begin errors++; $display("FAIL exc_single%0d got=%b exp=0000", i, pulses()); end
    end
    @(negedge clk);
    checks++;
    if ({commit_ok, flush} !== 2'b10) begin errors++; $display("FAIL exc_resume got=%b exp=10", {commit_ok, flush}); end
    tick();
    clear_wb();
  endtask

  task automatic test_int_priority();
    csr_ie = 1; csr_lie = 12'h800; csr_is = 12'h800;
    @(negedge clk);
    checks++;
    if ({commit_ok, flush} !== 2'b00) begin errors++; $display("FAIL int_novalid got=%b exp=00", {commit_ok, flush}); end
    tick();
    wb_valid = 1; wb_exc = 1; wb_excode = 6'h09; wb_badv = 32'h1234; wb_pc = 32'h1c000200;
    checks++;
    if (pulses() !== 4'b0000) begin errors++; $display("FAIL int_novalid_pulse got=%b exp=0000", pulses()); end
    @(negedge clk);
    checks++;
    if ({flush, commit_ok} !== 2'b10) begin errors++; $display("FAIL int_T got=%b exp=10", {flush, commit_ok}); end
    tick();
    clear_all();
    checks++;
    if (pulses() !== 4'b1000) begin errors++; $display("FAIL int_pulse got=%b exp=1000", pulses()); end
    checks++;
    if ({excode, esubcode, badvaddr, csr_pc} !== {INT_CODE, 9'h0, 32'h0, 32'h1c000200}) begin
      errors++; $display("FAIL int_payload got=%h/%h/%h/%h exp=00/000/0/1c000200", excode, esubcode, badvaddr, csr_pc);
    end
    wait_run();
  endtask

  task automatic test_ertn();
    wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1c000300;
    @(negedge clk);
    checks++;
    if ({commit_ok, flush} !== 2'b11) begin errors++; $display("FAIL ertn_T got=%b exp=11", {commit_ok, flush}); end
    tick();
    clear_wb();
    checks++;
    if (pulses() !== 4'b0100 || csr_pc !== 32'h1c000300) begin
      errors++; $display("FAIL ertn_pulse got=%b/%h exp=0100/1c000300", pulses(), csr_pc);
    end
    tick();
    checks++;
    if (pulses() !== 4'b0000) begin errors++; $display("FAIL ertn_single got=%b exp=0000", pulses()); end
    wait_run();
  endtask

  task automatic test_idle_wake();
    wb_valid = 1; wb_idle = 1; wb_pc = 32'h1c000400;
    csr_ie = 1; csr_is = 12'h004; csr_lie = 12'h000;
    @(negedge clk);
    checks++;
    if ({commit_ok, flush} !== 2'b11) begin errors++; $display("FAIL idle_T got=%b exp=11", {commit_ok, flush}); end
    tick();
    clear_wb();
    checks++;
    if (pulses() !== 4'b0001 || csr_pc !== 32'h1c000400) begin
      errors++; $display("FAIL idle_pulse got=%b/%h exp=0001/1c000400", pulses(), csr_pc);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({idle_stall, commit_ok, flush} !== 3'b101) begin
        errors++; $display("FAIL idle_wait%0d got=%b exp=101", i, {idle_stall, commit_ok, flush});
      end
      tick();
    end
    csr_lie = 12'h004;
    tick();
    clear_all();
    checks++;
    if (pulses() !== 4'b1000 || excode !== INT_CODE || csr_pc !== 32'h1c000400) begin
      errors++; $display("FAIL idle_wake got=%b/%h/%h exp=1000/00/1c000400", pulses(), excode, csr_pc);
    end
    checks++;
    if (idle_stall !== 1'b0) begin errors++; $display("FAIL idle_stall_fall got=%b exp=0", idle_stall); end
    wait_run();
  endtask

  task automatic test_hold_int_deferred();
    wb_valid = 1; wb_refetch = 1; wb_pc = 32'h1c000500;
    tick();
    clear_wb();
    checks++;
    if (pulses() !== 4'b0010) begin errors++; $display("FAIL refetch_pulse got=%b exp=0010", pulses()); end
    csr_ie = 1; csr_lie = 12'h001; csr_is = 12'h001;
    wb_valid = 1; wb_pc = 32'h1c000504;
    for (int i = 0; i < HOLDOFF; i++) begin
      tick();
      checks++;
      if (pulses() !== 4'b0000) begin errors++; $display("FAIL hold_int%0d got=%b exp=0000", i, pulses()); end
    end
    @(negedge clk);
    checks++;
    if ({flush, commit_ok} !== 2'b10) begin errors++; $display("FAIL defer_T got=%b exp=10", {flush, commit_ok}); end
    tick();
    clear_all();
    checks++;
    if (pulses() !== 4'b1000 || csr_pc !== 32'h1c000504) begin
      errors++; $display("FAIL defer_pulse got=%b/%h exp=1000/1c000504", pulses(), csr_pc);
    end
    wait_run();
  endtask

  task automatic test_reset_in_idle();
    wb_valid = 1; wb_idle = 1; wb_pc = 32'h1c000600;
    tick();
    clear_wb();
    tick();
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if ({idle_stall, flush, pulses()} !== 6'b0) begin
      errors++; $display("FAIL rst_idle got=%b exp=000000", {idle_stall, flush, pulses()});
    end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_idle_state got=%0d exp=0", dbg_state); end
`ifdef EXC_TRACE_EN
    checks++;
    if (exc_count !== 32'd0) begin errors++; $display("FAIL rst_idle_count got=%0d exp=0", exc_count); end
`endif
  endtask

  // Reference model: remaining blocked cycles, idle flag and last-reported payload.
  task automatic test_random();
    int          m_hold;
    bit          m_idle, ip;
    logic [31:0] m_pc, m_badv;
    logic [5:0]  m_excode;
    logic [8:0]  m_esub;
    logic [3:0]  m_pulse, n_pulse;
    logic [2:0]  e_ctl;
    logic [31:0] m_cnt;
    logic [5:0]  m_last;
    do_reset();
    m_hold = 0; m_idle = 0; m_pc = '0; m_badv = '0; m_excode = '0; m_esub = '0;
    m_pulse = '0; m_cnt = '0; m_last = '0;
    for (int n = 0; n < 3000; n++) begin
      checks++;
      if (pulses() !== m_pulse || csr_pc !== m_pc) begin
        errors++; $display("FAIL rnd_out n=%0d got=%b/%h exp=%b/%h", n, pulses(), csr_pc, m_pulse, m_pc);
      end
      if (m_pulse[3]) begin
        checks++;
        if ({excode, esubcode, badvaddr} !== {m_excode, m_esub, m_badv}) begin
          errors++; $display("FAIL rnd_payload n=%0d got=%h/%h/%h exp=%h/%h/%h", n, excode, esubcode, badvaddr, m_excode, m_esub, m_badv);
        end
      end
`ifdef EXC_TRACE_EN
      checks++;
      if (exc_count !== m_cnt || last_excode !== m_last) begin
        errors++; $display("FAIL rnd_trace n=%0d got=%0d/%h exp=%0d/%h", n, exc_count, last_excode, m_cnt, m_last);
      end
`endif
      reset = ($urandom_range(0, 99) == 0);
      wb_valid = ($urandom_range(0, 3) != 0);
      wb_pc = {$urandom_range(0, 65535), 16'h0} | {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
      wb_exc = ($urandom_range(0, 9) == 0);
      wb_ertn = ($urandom_range(0, 9) == 0);
      wb_refetch = ($urandom_range(0, 9) == 0);
      wb_idle = ($urandom_range(0, 9) == 0);
      wb_excode = 6'($urandom_range(0, 63));
      wb_esubcode = 9'($urandom_range(0, 511));
      wb_badv = $urandom;
      csr_ie = ($urandom_range(0, 3) != 0);
      csr_lie = 12'($urandom_range(0, 4095));
      csr_is = ($urandom_range(0, 7) == 0) ? (12'd1 << $urandom_range(0, 11)) : 12'd0;
      ip = csr_ie && ((csr_is & csr_lie) != 12'd0);
      n_pulse = 4'b0000;
      // e_ctl = {commit_ok, flush, idle_stall}
      if (reset) begin
        e_ctl = 3'b000;
      end else if (m_idle) begin
        e_ctl = 3'b011;
        if (ip) begin
          n_pulse = 4'b1000; m_excode = INT_CODE; m_esub = '0; m_badv = '0;
          m_idle = 0; m_hold = HOLDOFF;
        end
      end else if (m_hold > 0) begin
        e_ctl = 3'b010;
        m_hold--;
      end else if (!wb_valid) begin
        e_ctl = 3'b000;
      end else if (ip || wb_exc) begin
        e_ctl = 3'b010; n_pulse = 4'b1000; m_pc = wb_pc; m_hold = HOLDOFF;
        if (ip) begin m_excode = INT_CODE; m_esub = '0; m_badv = '0; end
        else begin m_excode = wb_excode; m_esub = wb_esubcode; m_badv = wb_badv; end
      end else if (wb_ertn) begin
        e_ctl = 3'b110; n_pulse = 4'b0100; m_pc = wb_pc; m_hold = HOLDOFF;
      end else if (wb_refetch) begin
        e_ctl = 3'b110; n_pulse = 4'b0010; m_pc = wb_pc; m_hold = HOLDOFF;
      end else if (wb_idle) begin
        e_ctl = 3'b110; n_pulse = 4'b0001; m_pc = wb_pc; m_idle = 1;
      end else begin
        e_ctl = 3'b100;
      end
      if (n_pulse[3]) begin m_cnt = m_cnt + 32'd1; m_last = m_excode; end
      @(negedge clk);
      checks++;
      if ({commit_ok, flush, idle_stall} !== e_ctl) begin
        errors++; $display("FAIL rnd_ctl n=%0d got=%b exp=%b", n, {commit_ok, flush, idle_stall}, e_ctl);
      end
      tick();
      m_pulse = n_pulse;
      if (reset) begin
        m_hold = 0; m_idle = 0; m_pc = '0; m_badv = '0; m_excode = '0; m_esub = '0;
        m_pulse = '0; m_cnt = '0; m_last = '0;
      end
    end
    reset = 0;
    clear_all();
    checks++;
    if (pulses() !== m_pulse) begin errors++; $display("FAIL rnd_last got=%b exp=%b", pulses(), m_pulse); end
  endtask

  initial begin
    reset = 1;
    clear_all();
    test_reset();
    test_exc();
    test_int_priority();
    test_ertn();
    test_idle_wake();
    test_hold_int_deferred();
    test_reset_in_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
